// File: rtl/rate_encoder.sv
// rate_encoder: buffers one pixel frame, then emits NUM_STEPS rate-coded spike vectors and a gap.
// Latency: step 0 appears one edge after the last pixel is accepted; out_valid then stays high NUM_STEPS cycles.
// Backpressure: pixel_ready only in IDLE/LOAD, no output stall. Optional RATE_ENC_LFSR_EN gives random per-channel phase.
module rate_encoder #(
    parameter int          INPUT_SIZE  = 16,
    parameter int          PIXEL_WIDTH = 8,
    parameter int          NUM_STEPS   = 16,
    parameter int          STEP_WIDTH  = 8,
    parameter int          GAP_CYCLES  = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    output logic [INPUT_SIZE-1:0]  spike,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    if (NUM_STEPS < 1 || GAP_CYCLES < 1 || (2 ** STEP_WIDTH) <= NUM_STEPS || LFSR_SEED == 16'h0)
    begin : g_param_err
        $error("rate_encoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       load_idx_q, load_idx_d;
    logic [STEP_WIDTH-1:0]  step_q, step_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [PIXEL_WIDTH-1:0] pix_q [INPUT_SIZE];
    logic [PIXEL_WIDTH-1:0] pix_d [INPUT_SIZE];
    logic [PIXEL_WIDTH-1:0] acc_q [INPUT_SIZE];
    logic [PIXEL_WIDTH-1:0] acc_d [INPUT_SIZE];
    logic [PIXEL_WIDTH:0]   sum   [INPUT_SIZE];
    logic [INPUT_SIZE-1:0]  spike_q, spike_d;
    logic                   out_valid_q, out_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   beat;
    logic                   last_pix;
    logic [PIXEL_WIDTH-1:0] init_val;

    assign pixel_ready = !rst && (state_q == IDLE || state_q == LOAD);
    assign beat        = pixel_valid && pixel_ready;
    assign last_pix    = (load_idx_q == IDX_W'(INPUT_SIZE - 1));
    assign busy        = (state_q == RUN || state_q == GAP);
    assign spike       = spike_q;
    assign out_valid   = out_valid_q;
    assign frame_done  = frame_done_q;

`ifdef RATE_ENC_LFSR_EN
    // Free-running across frames: only reset reseeds it, so phases differ frame to frame.
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (beat) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign init_val = lfsr_q[PIXEL_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign init_val = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
`endif

    always_comb begin
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        step_d       = step_q;
        gap_d        = gap_q;
        pix_d        = pix_q;
        acc_d        = acc_q;
        spike_d      = spike_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            sum[i] = {1'b0, acc_q[i]} + {1'b0, pix_q[i]};
        end

        case (state_q)
            IDLE, LOAD: begin
                // Accumulator phase is written alongside its pixel, so RUN starts with every channel primed.
                if (beat) begin
                    pix_d[load_idx_q] = pixel_data;
                    acc_d[load_idx_q] = init_val;
                    if (last_pix) begin
                        state_d    = RUN;
                        load_idx_d = '0;
                        step_d     = '0;
                    end else begin
                        state_d    = LOAD;
                        load_idx_d = load_idx_q + IDX_W'(1);
                    end
                end
            end
            RUN: begin
                for (int i = 0; i < INPUT_SIZE; i++) begin
                    spike_d[i] = sum[i][PIXEL_WIDTH];
                    acc_d[i]   = sum[i][PIXEL_WIDTH-1:0];
                end
                out_valid_d = 1'b1;
                step_d      = step_q + STEP_WIDTH'(1);
                if (step_q == STEP_WIDTH'(NUM_STEPS - 1)) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                // First GAP cycle still shows the last step; the low-valid window follows it.
                spike_d     = '0;
                out_valid_d = 1'b0;
                if (gap_q == GAP_W'(GAP_CYCLES)) begin
                    state_d = IDLE;
                end else begin
                    gap_d        = gap_q + GAP_W'(1);
                    frame_done_d = (gap_q == GAP_W'(GAP_CYCLES - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            load_idx_q   <= '0;
            step_q       <= '0;
            gap_q        <= '0;
            spike_q      <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                pix_q[i] <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            spike_q      <= spike_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            pix_q        <= pix_d;
            acc_q        <= acc_d;
        end
    end

endmodule

// File: tb/tb_rate_encoder.sv
// Bench for rate_encoder (default build): table-driven frames, reset corner cases, randomized frames vs closed-form model.
module tb_rate_encoder;
    localparam int N     = 16;
    localparam int STEPS = 16;
    localparam int GAP   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   pixel_data = 8'h00;
    logic         pixel_valid = 1'b0;
    logic         pixel_ready;
    logic [N-1:0] spike;
    logic         out_valid;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    rate_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .spike      (spike),
        .out_valid  (out_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] cur_px [N];
    int         cnt    [N];

    typedef struct {
        logic [7:0] px0, px1, px2, pxr;
        int         c0, c1, c2, cr;
    } vec_t;
    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spike at step k iff the running total init + n*p crosses a multiple of 256 between n=k and n=k+1.
    function automatic logic [N-1:0] exp_spike(input int k);
        logic [N-1:0] v;
        int a, b;
        v = '0;
        for (int i = 0; i < N; i++) begin
            a = (128 + (k + 1) * int'(cur_px[i])) / 256;
            b = (128 + k * int'(cur_px[i])) / 256;
            v[i] = (a != b);
        end
        return v;
    endfunction

    task automatic drive_cycle(input int vprob);
        pixel_valid = ($urandom_range(0, 99) < vprob);
        pixel_data  = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int vprob, input int nbeats);
        int   idx;
        int   cyc;
        logic b;
        idx = 0;
        cyc = 0;
        while (idx < nbeats && cyc < 2000) begin
            pixel_valid = ($urandom_range(0, 99) < vprob);
            pixel_data  = pixel_valid ? cur_px[idx] : 8'($urandom);
            b = pixel_valid && pixel_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (b) idx++;
        end
        pixel_valid = 1'b0;
        if (idx < nbeats) check("load_timeout", idx, nbeats);
    endtask

    task automatic collect_frame(input int vprob);
        logic [N-1:0] e;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        check("ready_low_in_run", 32'(pixel_ready), 0);
        check("no_valid_before_step0", 32'(out_valid), 0);
        for (int k = 0; k < STEPS; k++) begin
            drive_cycle(vprob);
            e = exp_spike(k);
            check($sformatf("valid_step%0d", k), 32'(out_valid), 1);
            check($sformatf("spike_step%0d", k), 32'(spike), 32'(e));
            for (int i = 0; i < N; i++) if (spike[i]) cnt[i]++;
        end
        for (int g = 1; g <= GAP; g++) begin
            drive_cycle(vprob);
            check($sformatf("gap%0d_valid", g), 32'(out_valid), 0);
            check($sformatf("gap%0d_spike", g), 32'(spike), 0);
            check($sformatf("gap%0d_busy", g), 32'(busy), 1);
            check($sformatf("gap%0d_ready", g), 32'(pixel_ready), 0);
            check($sformatf("gap%0d_done", g), 32'(frame_done), 32'(g == GAP));
        end
        drive_cycle(vprob);
        pixel_valid = 1'b0;
        check("idle_ready", 32'(pixel_ready), 1);
        check("idle_done_low", 32'(frame_done), 0);
        check("idle_busy_low", 32'(busy), 0);
    endtask

    task automatic check_count_range();
        int lo, hi;
        for (int i = 0; i < N; i++) begin
            lo = (int'(cur_px[i]) * STEPS) / 256;
            hi = lo + (((int'(cur_px[i]) * STEPS) % 256 != 0) ? 1 : 0);
            check($sformatf("count_range_ch%0d", i), 32'(cnt[i] >= lo && cnt[i] <= hi), 1);
        end
    endtask

    task automatic pulse_reset_and_check(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 32'(out_valid), 0);
        check({tag, "_rst_spike"}, 32'(spike), 0);
        check({tag, "_rst_busy"}, 32'(busy), 0);
        check({tag, "_rst_ready"}, 32'(pixel_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check({tag, "_post_rst_ready"}, 32'(pixel_ready), 1);
    endtask

    initial begin
        tbl[0] = '{px0: 8'd128, px1: 8'd128, px2: 8'd128, pxr: 8'd128, c0: 8,  c1: 8,  c2: 8,  cr: 8};
        tbl[1] = '{px0: 8'd0,   px1: 8'd64,  px2: 8'd255, pxr: 8'd128, c0: 0,  c1: 4,  c2: 16, cr: 8};
        tbl[2] = '{px0: 8'd1,   px1: 8'd192, px2: 8'd32,  pxr: 8'd200, c0: 0,  c1: 12, c2: 2,  cr: 13};
        tbl[3] = '{px0: 8'd255, px1: 8'd17,  px2: 8'd0,   pxr: 8'd16,  c0: 16, c1: 1,  c2: 0,  cr: 1};
        tbl[4] = tbl[0];

        #3;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_spike", 32'(spike), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(frame_done), 0);
        check("reset_ready", 32'(pixel_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("after_reset_ready", 32'(pixel_ready), 1);

        // Table rows run back to back; rows 0 and 4 hold pixel_valid high throughout.
        for (int r = 0; r < 5; r++) begin
            cur_px[0] = tbl[r].px0;
            cur_px[1] = tbl[r].px1;
            cur_px[2] = tbl[r].px2;
            for (int i = 3; i < N; i++) cur_px[i] = tbl[r].pxr;
            load_frame((tbl[r].px0 == 8'd128) ? 100 : 60, N);
            collect_frame((tbl[r].px0 == 8'd128) ? 100 : 40);
            check($sformatf("row%0d_count_ch0", r), cnt[0], tbl[r].c0);
            check($sformatf("row%0d_count_ch1", r), cnt[1], tbl[r].c1);
            check($sformatf("row%0d_count_ch2", r), cnt[2], tbl[r].c2);
            check($sformatf("row%0d_count_ch15", r), cnt[15], tbl[r].cr);
        end

        // Reset while RUN is emitting step 5.
        for (int i = 0; i < N; i++) cur_px[i] = 8'(i * 16 + 3);
        load_frame(100, N);
        for (int k = 0; k < 6; k++) drive_cycle(50);
        check("midrun_valid_before_rst", 32'(out_valid), 1);
        check("midrun_spike_step5", 32'(spike), 32'(exp_spike(5)));
        pulse_reset_and_check("midrun");
        for (int i = 0; i < N; i++) cur_px[i] = 8'(255 - i * 15);
        load_frame(70, N);
        collect_frame(50);
        check_count_range();

        // Reset after 7 load beats; the following frame must not inherit them.
        for (int i = 0; i < N; i++) cur_px[i] = 8'd250;
        load_frame(100, 7);
        check("midload_busy", 32'(busy), 0);
        pulse_reset_and_check("midload");
        for (int i = 0; i < N; i++) cur_px[i] = 8'(i * 9);
        load_frame(100, N);
        collect_frame(0);
        check("midload_count_ch0", cnt[0], 0);
        check("midload_count_ch15", cnt[15], 8);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < N; i++) cur_px[i] = 8'($urandom);
            if (f == 0) cur_px[3] = 8'd0;
            if (f == 0) cur_px[4] = 8'd255;
            load_frame(50, N);
            collect_frame(50);
            check_count_range();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
